// File: rtl/dac_sample_pacer.sv
// dac_sample_pacer: FIFO-buffered sample pacer for a parallel ladder DAC.
// Ports: clk, rst_n, enable, s_valid/s_data/s_ready in, clr_underflow,
// dac_out, dac_strobe, underflow, level.
module dac_sample_pacer #(
    parameter int DATA_W      = 10,
    parameter int DEPTH       = 8,
    parameter int TICK_DIV    = 24,
    parameter int PRIME_LEVEL = 4,
    parameter int MIDSCALE    = 512
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     s_valid,
    input  logic [DATA_W-1:0]        s_data,
    output logic                     s_ready,
    input  logic                     clr_underflow,
    output logic [DATA_W-1:0]        dac_out,
    output logic                     dac_strobe,
    output logic                     underflow,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(TICK_DIV);

    localparam logic [LW-1:0]     DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0]     PRIME_L = LW'(PRIME_LEVEL);
    localparam logic [CW-1:0]     CNT_MAX = CW'(TICK_DIV - 1);
    localparam logic [DATA_W-1:0] MID     = DATA_W'(MIDSCALE);

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic push;
    logic pop;
    logic tick;
    logic empty;

    // Ready comes from the registered level only, so a full FIFO
    // refuses a write even on a cycle that pops.
    assign s_ready = (level != DEPTH_L);
    assign empty   = (level == '0);
    assign push    = s_valid && s_ready;
    assign tick    = (state == RUN) && (cnt == CNT_MAX);
    assign pop     = tick && !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            dac_out    <= MID;
            dac_strobe <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            if (!enable) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        state <= PRIME;
                        cnt   <= '0;
                    end
                    PRIME: begin
                        cnt <= '0;
                        if (level >= PRIME_L) begin
                            state <= RUN;
                        end
                    end
                    RUN: begin
                        cnt <= tick ? '0 : cnt + 1'b1;
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end

            dac_strobe <= pop;
            if (pop) begin
                dac_out <= mem[rptr];
            end

            // A starved tick wins over a clear arriving the same cycle.
            if (tick && empty) begin
                underflow <= 1'b1;
            end else if (clr_underflow) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dac_sample_pacer.sv
// tb_dac_sample_pacer: directed bench with a sample scoreboard.
// Expected DAC codes are queued on accepted writes and popped on strobes.
module tb_dac_sample_pacer;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       s_valid;
    logic [9:0] s_data;
    logic       s_ready;
    logic       clr_underflow;
    logic [9:0] dac_out;
    logic       dac_strobe;
    logic       underflow;
    logic [3:0] level;

    int errors = 0;
    int checks = 0;
    logic [9:0] sb [$];

    dac_sample_pacer #(
        .DATA_W(10),
        .DEPTH(8),
        .TICK_DIV(4),
        .PRIME_LEVEL(4),
        .MIDSCALE(512)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .s_valid(s_valid),
        .s_data(s_data),
        .s_ready(s_ready),
        .clr_underflow(clr_underflow),
        .dac_out(dac_out),
        .dac_strobe(dac_strobe),
        .underflow(underflow),
        .level(level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic cyc();
        logic [9:0] e;
        if (s_valid && s_ready) sb.push_back(s_data);
        @(posedge clk);
        #1;
        if (dac_strobe) begin
            if (sb.size() == 0) begin
                chk("unexpected_strobe", 32'(dac_strobe), 0);
            end else begin
                e = sb.pop_front();
                chk("dac_out", 32'(dac_out), 32'(e));
            end
        end
    endtask

    task automatic wait_strobe(output int n);
        n = -1;
        for (int i = 1; i <= 50; i++) begin
            cyc();
            if (dac_strobe) begin
                n = i;
                break;
            end
        end
        if (n < 0) chk("strobe_timeout", 32'(dac_strobe), 1);
    endtask

    initial begin
        int n;
        logic [9:0] vals [4];
        vals[0] = 10'h000;
        vals[1] = 10'h3FF;
        vals[2] = 10'h200;
        vals[3] = 10'h155;

        rst_n = 1'b1;
        enable = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        clr_underflow = 1'b0;

        // reset
        #2 rst_n = 1'b0;
        #2;
        chk("rst_dac_out", 32'(dac_out), 32'h200);
        chk("rst_s_ready", 32'(s_ready), 1);
        chk("rst_level", 32'(level), 0);
        chk("rst_underflow", 32'(underflow), 0);
        chk("rst_strobe", 32'(dac_strobe), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // prime and pace
        enable = 1'b1;
        cyc();
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_data = vals[i];
            cyc();
        end
        s_valid = 1'b0;
        chk("prime_level", 32'(level), 4);
        for (int i = 0; i < 4; i++) begin
            wait_strobe(n);
            chk("pace_gap", 32'(n), (i == 0) ? 5 : 4);
            chk("pace_level", 32'(level), 32'(3 - i));
        end

        // underflow
        for (int i = 0; i < 3; i++) cyc();
        chk("uf_not_yet", 32'(underflow), 0);
        cyc();
        chk("uf_set", 32'(underflow), 1);
        chk("uf_hold", 32'(dac_out), 32'h155);
        chk("uf_no_strobe", 32'(dac_strobe), 0);
        clr_underflow = 1'b1;
        cyc();
        chk("uf_clear", 32'(underflow), 0);
        clr_underflow = 1'b0;
        cyc();
        cyc();
        clr_underflow = 1'b1;
        cyc();
        chk("uf_set_beats_clr", 32'(underflow), 1);
        cyc();
        chk("uf_clear2", 32'(underflow), 0);
        clr_underflow = 1'b0;

        // push coinciding with pop
        s_valid = 1'b1;
        s_data = 10'h0A1;
        cyc();
        s_data = 10'h0B2;
        cyc();
        chk("pp_level_pre", 32'(level), 2);
        s_data = 10'h0C3;
        cyc();
        s_valid = 1'b0;
        chk("pp_strobe", 32'(dac_strobe), 1);
        chk("pp_level", 32'(level), 2);
        for (int i = 0; i < 2; i++) begin
            wait_strobe(n);
            chk("pp_gap", 32'(n), 4);
        end
        chk("pp_drained", 32'(level), 0);

        // backpressure
        enable = 1'b0;
        cyc();
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1;
            s_data = 10'(10'h100 + 10'(i * 37));
            cyc();
        end
        chk("bp_ready", 32'(s_ready), 0);
        chk("bp_level", 32'(level), 8);
        s_data = 10'h2AA;
        cyc();
        cyc();
        chk("bp_held_level", 32'(level), 8);
        chk("bp_held_dac", 32'(dac_out), 32'h0C3);
        enable = 1'b1;
        wait_strobe(n);
        chk("bp_first_gap", 32'(n), 6);
        chk("bp_ready_after_pop", 32'(s_ready), 1);
        cyc();
        s_valid = 1'b0;
        chk("bp_refill", 32'(level), 8);
        for (int i = 0; i < 8; i++) begin
            wait_strobe(n);
            chk("bp_gap", 32'(n), (i == 0) ? 3 : 4);
        end
        chk("bp_sb_empty", 32'(sb.size()), 0);
        for (int i = 0; i < 4; i++) cyc();
        chk("bp_uf", 32'(underflow), 1);

        // async reset mid-run
        s_valid = 1'b1;
        s_data = 10'h011;
        cyc();
        s_data = 10'h022;
        cyc();
        s_valid = 1'b0;
        chk("ar_level_pre", 32'(level), 2);
        #3 rst_n = 1'b0;
        #1;
        chk("ar_dac_out", 32'(dac_out), 32'h200);
        chk("ar_level", 32'(level), 0);
        chk("ar_ready", 32'(s_ready), 1);
        chk("ar_underflow", 32'(underflow), 0);
        chk("ar_strobe", 32'(dac_strobe), 0);
        sb.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc();
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_data = vals[3 - i];
            cyc();
        end
        s_valid = 1'b0;
        wait_strobe(n);
        chk("ar_restart_gap", 32'(n), 5);
        chk("ar_restart_level", 32'(level), 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
